// File: rtl/ssi_angle_track_pkg.sv
// -----------------------------------------------------------------------------
// ssi_angle_track_pkg
// Shared definitions for the SSI angle tracker:
//   - one-hot FSM state encoding (IDLE / REQ / WAIT / CALC)
//   - datapath widths (single-turn angle, multi-turn count, velocity)
//   - default request period and frame timeout (clk cycles at 200 MHz)
//   - wrap_delta(): modular angle difference, sign-extended to VEL_W
// -----------------------------------------------------------------------------
package ssi_angle_track_pkg;

    localparam int ANGLE_W     = 23;
    localparam int TURN_W      = 16;
    localparam int VEL_W       = ANGLE_W + 1;
    localparam int ERR_W       = 8;
    localparam int CNT_REQ_DEF = 20000;
    localparam int CNT_TMO_DEF = 16000;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_REQ  = 4'b0010,
        ST_WAIT = 4'b0100,
        ST_CALC = 4'b1000
    } state_t;

    // (new - old) mod 2^ANGLE_W read as a signed ANGLE_W value, sign-extended.
    function automatic logic [VEL_W-1:0] wrap_delta(
        input logic [ANGLE_W-1:0] new_a,
        input logic [ANGLE_W-1:0] old_a
    );
        logic [ANGLE_W-1:0] diff;
        diff = new_a - old_a;
        return {diff[ANGLE_W-1], diff};
    endfunction

endpackage

// File: rtl/ssi_gray2bin.sv
// -----------------------------------------------------------------------------
// ssi_gray2bin
// Combinational Gray-to-binary converter, width-parameterised.
//   gray : Gray-coded input word
//   bin  : binary word, bin[W-1] = gray[W-1], bin[i] = bin[i+1] ^ gray[i]
// Implemented as a log-depth suffix XOR so no signal depends on itself.
// -----------------------------------------------------------------------------
module ssi_gray2bin
    import ssi_angle_track_pkg::*;
#(
    parameter int W = ANGLE_W
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    logic [W-1:0] acc_s;

    // Each pass folds in bits 2x further away; after log2(W) passes every bit
    // holds the XOR of itself and all more-significant Gray bits.
    always_comb begin
        acc_s = gray;
        for (int s = 1; s < W; s = s * 2) begin
            acc_s = acc_s ^ (acc_s >> s);
        end
        bin = acc_s;
    end

endmodule

// File: rtl/ssi_angle_track.sv
// -----------------------------------------------------------------------------
// ssi_angle_track
// Periodically requests a single-turn angle from an SSI reader, decodes it and
// tracks position, multi-turn count and per-frame velocity, rejecting frames
// whose change is implausibly large.
// Ports:
//   clk, rst        : 200 MHz clock, asynchronous active-high reset
//   en              : tracking enable (low forces IDLE and re-arms first frame)
//   angle_in        : single-turn frame (Gray or binary, see GRAY_EN)
//   angle_valid     : one-cycle strobe qualifying angle_in
//   key_out         : one-cycle request pulse to the reader
//   pos_out         : binary single-turn position
//   turn_out        : signed multi-turn count (wraps mod 2^16)
//   vel_out         : signed delta of the last accepted frame
//   pos_valid       : one-cycle strobe on each output update
//   err_jump        : one-cycle strobe on a rejected frame
//   err_tmo         : one-cycle strobe on a frame timeout
//   err_cnt         : saturating error count
// -----------------------------------------------------------------------------
module ssi_angle_track
    import ssi_angle_track_pkg::*;
#(
    parameter int CNT_REQ   = CNT_REQ_DEF,
    parameter int CNT_TMO   = CNT_TMO_DEF,
    parameter int GRAY_EN   = 1,
    parameter int DELTA_MAX = 262144
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [ANGLE_W-1:0] angle_in,
    input  logic               angle_valid,
    output logic               key_out,
    output logic [ANGLE_W-1:0] pos_out,
    output logic [TURN_W-1:0]  turn_out,
    output logic [VEL_W-1:0]   vel_out,
    output logic               pos_valid,
    output logic               err_jump,
    output logic               err_tmo,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int              PER_W     = (CNT_REQ > 2) ? $clog2(CNT_REQ) : 1;
    localparam int              TMO_W     = (CNT_TMO > 2) ? $clog2(CNT_TMO) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(CNT_REQ - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CNT_TMO - 1);
    localparam logic [31:0]     DELTA_LIM = 32'(DELTA_MAX);
    localparam logic [1:0]      REJ_LIMIT = 2'd2;
    localparam logic [ERR_W-1:0] ERR_SAT  = 8'd255;

    state_t             state_r;
    state_t             state_nx_s;
    logic [PER_W-1:0]   per_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [ANGLE_W-1:0] dec_s;
    logic [ANGLE_W-1:0] new_angle_s;
    logic [ANGLE_W-1:0] new_r;
    logic               first_r;
    logic [1:0]         rej_cnt_r;
    logic [VEL_W-1:0]   delta_s;
    logic [VEL_W-1:0]   delta_abs_s;
    logic               too_big_s;

    logic               capture_s;
    logic               tmo_hit_s;
    logic               acc_first_s;
    logic               acc_norm_s;
    logic               reject_s;
    logic               turn_inc_s;
    logic               turn_dec_s;

    logic               key_out_r;
    logic [ANGLE_W-1:0] pos_out_r;
    logic [TURN_W-1:0]  turn_out_r;
    logic [VEL_W-1:0]   vel_out_r;
    logic               pos_valid_r;
    logic               err_jump_r;
    logic               err_tmo_r;
    logic [ERR_W-1:0]   err_cnt_r;

    ssi_gray2bin #(
        .W    (ANGLE_W)
    ) u_gray2bin (
        .gray (angle_in),
        .bin  (dec_s)
    );

    // Select decoded or raw frame depending on the reader's coding.
    always_comb begin
        if (GRAY_EN != 0) begin
            new_angle_s = dec_s;
        end else begin
            new_angle_s = angle_in;
        end
    end

    // Signed frame delta and its plausibility against DELTA_MAX.
    always_comb begin
        delta_s = wrap_delta(new_r, pos_out_r);
        if (delta_s[VEL_W-1]) begin
            delta_abs_s = {VEL_W{1'b0}} - delta_s;
        end else begin
            delta_abs_s = delta_s;
        end
        too_big_s = (32'(delta_abs_s) > DELTA_LIM);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; a valid frame wins over a coincident timeout.
    always_comb begin
        state_nx_s = state_r;
        if (!en) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (per_cnt_r == PER_LAST) begin
                        state_nx_s = ST_REQ;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_REQ:  state_nx_s = ST_WAIT;
                ST_WAIT: begin
                    if (angle_valid) begin
                        state_nx_s = ST_CALC;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end
                ST_CALC: state_nx_s = ST_IDLE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode: per-cycle decisions consumed by the registers below.
    always_comb begin
        capture_s   = 1'b0;
        tmo_hit_s   = 1'b0;
        acc_first_s = 1'b0;
        acc_norm_s  = 1'b0;
        reject_s    = 1'b0;
        turn_inc_s  = 1'b0;
        turn_dec_s  = 1'b0;
        if (!en) begin
            capture_s = 1'b0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    capture_s = angle_valid;
                    tmo_hit_s = !angle_valid && (tmo_cnt_r == TMO_LAST);
                end
                ST_CALC: begin
                    // Third consecutive implausible frame is trusted as a restart.
                    if (first_r || (too_big_s && (rej_cnt_r == REJ_LIMIT))) begin
                        acc_first_s = 1'b1;
                    end else if (too_big_s) begin
                        reject_s = 1'b1;
                    end else begin
                        acc_norm_s = 1'b1;
                        // Crossing zero: forward wrap lands below old, reverse above.
                        turn_inc_s = (new_r < pos_out_r) && !delta_s[VEL_W-1]
                                     && (delta_s != {VEL_W{1'b0}});
                        turn_dec_s = (new_r > pos_out_r) && delta_s[VEL_W-1];
                    end
                end
                default: capture_s = 1'b0;
            endcase
        end
    end

    // Period counter free-runs while enabled; the timeout window is measured
    // from the request strobe, so it runs through REQ and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt_r <= {PER_W{1'b0}};
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (!en) begin
            per_cnt_r <= {PER_W{1'b0}};
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            if (per_cnt_r == PER_LAST) begin
                per_cnt_r <= {PER_W{1'b0}};
            end else begin
                per_cnt_r <= per_cnt_r + PER_W'(1);
            end
            if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
        end
    end

    // Frame capture, first-frame/reject bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_r       <= {ANGLE_W{1'b0}};
            first_r     <= 1'b1;
            rej_cnt_r   <= 2'd0;
            key_out_r   <= 1'b0;
            pos_out_r   <= {ANGLE_W{1'b0}};
            turn_out_r  <= {TURN_W{1'b0}};
            vel_out_r   <= {VEL_W{1'b0}};
            pos_valid_r <= 1'b0;
            err_jump_r  <= 1'b0;
            err_tmo_r   <= 1'b0;
            err_cnt_r   <= {ERR_W{1'b0}};
        end else begin
            key_out_r   <= (state_nx_s == ST_REQ);
            pos_valid_r <= acc_first_s || acc_norm_s;
            err_jump_r  <= reject_s;
            err_tmo_r   <= tmo_hit_s;

            if (capture_s) begin
                new_r <= new_angle_s;
            end else begin
                new_r <= new_r;
            end

            if (acc_first_s) begin
                pos_out_r <= new_r;
                vel_out_r <= {VEL_W{1'b0}};
                rej_cnt_r <= 2'd0;
                first_r   <= 1'b0;
            end else if (acc_norm_s) begin
                pos_out_r <= new_r;
                vel_out_r <= delta_s;
                rej_cnt_r <= 2'd0;
                if (turn_inc_s) begin
                    turn_out_r <= turn_out_r + TURN_W'(1);
                end else if (turn_dec_s) begin
                    turn_out_r <= turn_out_r - TURN_W'(1);
                end else begin
                    turn_out_r <= turn_out_r;
                end
            end else if (reject_s) begin
                rej_cnt_r <= rej_cnt_r + 2'd1;
            end else if (!en) begin
                // Disabled: hold outputs, forget history so tracking restarts cleanly.
                first_r   <= 1'b1;
                rej_cnt_r <= 2'd0;
            end else begin
                rej_cnt_r <= rej_cnt_r;
            end

            if ((reject_s || tmo_hit_s) && (err_cnt_r != ERR_SAT)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign key_out   = key_out_r;
    assign pos_out   = pos_out_r;
    assign turn_out  = turn_out_r;
    assign vel_out   = vel_out_r;
    assign pos_valid = pos_valid_r;
    assign err_jump  = err_jump_r;
    assign err_tmo   = err_tmo_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_ssi_angle_track.sv
// -----------------------------------------------------------------------------
// tb_ssi_angle_track
// Directed, table-driven bench for ssi_angle_track with a shortened request
// period and timeout so that error-count saturation fits in a short run.
// -----------------------------------------------------------------------------
module tb_ssi_angle_track;

    localparam int T_REQ = 100;
    localparam int T_TMO = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [22:0] angle_in = 23'd0;
    logic        angle_valid = 1'b0;
    logic        key_out;
    logic [22:0] pos_out;
    logic [15:0] turn_out;
    logic [23:0] vel_out;
    logic        pos_valid;
    logic        err_jump;
    logic        err_tmo;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;

    ssi_angle_track #(
        .CNT_REQ    (T_REQ),
        .CNT_TMO    (T_TMO),
        .GRAY_EN    (1),
        .DELTA_MAX  (262144)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .angle_in    (angle_in),
        .angle_valid (angle_valid),
        .key_out     (key_out),
        .pos_out     (pos_out),
        .turn_out    (turn_out),
        .vel_out     (vel_out),
        .pos_valid   (pos_valid),
        .err_jump    (err_jump),
        .err_tmo     (err_tmo),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] ang;
        int          dl;
        logic        exp_pv;
        logic        exp_jmp;
        logic [22:0] exp_pos;
        logic [23:0] exp_vel;
        logic [15:0] exp_turn;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [22:0] to_gray(input logic [22:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ticks until key_out is seen; n is the number of ticks taken.
    task automatic wait_key(output int n);
        n = 0;
        while ((key_out !== 1'b1) && (n < T_REQ + 10)) begin
            tick();
            n++;
        end
        if (key_out !== 1'b1) begin
            check("key_timeout", 32'(key_out), 32'd1);
        end
    endtask

    // Waits for a request, delivers one frame dl+1 cycles into the request
    // window and checks the registered result two cycles after angle_valid.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        logic pv1;
        logic tmo1;
        wait_key(n);
        tick();
        for (int k = 0; k < v.dl; k++) tick();
        angle_in    = to_gray(v.ang);
        angle_valid = 1'b1;
        tick();
        angle_valid = 1'b0;
        pv1  = pos_valid;
        tmo1 = err_tmo;
        tick();
        check({tag, " pv_early"}, 32'(pv1), 32'd0);
        check({tag, " no_tmo"}, 32'(tmo1), 32'd0);
        check({tag, " pos_valid"}, 32'(pos_valid), 32'(v.exp_pv));
        check({tag, " err_jump"}, 32'(err_jump), 32'(v.exp_jmp));
        check({tag, " pos"}, 32'(pos_out), 32'(v.exp_pos));
        check({tag, " vel"}, 32'(vel_out), 32'(v.exp_vel));
        check({tag, " turn"}, 32'(turn_out), 32'(v.exp_turn));
        check({tag, " err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
        tick();
        check({tag, " pulse_len"}, 32'({pos_valid, err_jump}), 32'd0);
    endtask

    initial begin
        int   n;
        logic seen;
        vec_t v;

        //        ang        dl        pv    jmp   pos        vel          turn    err
        vecs[0]  = '{23'h7FFF00, 0,       1'b1, 1'b0, 23'h7FFF00, 24'h000000, 16'h0000, 8'd0};
        vecs[1]  = '{23'h000100, 3,       1'b1, 1'b0, 23'h000100, 24'h000200, 16'h0001, 8'd0};
        vecs[2]  = '{23'h7FFF00, 10,      1'b1, 1'b0, 23'h7FFF00, 24'hFFFE00, 16'h0000, 8'd0};
        vecs[3]  = '{23'h7FFF00, T_TMO-2, 1'b1, 1'b0, 23'h7FFF00, 24'h000000, 16'h0000, 8'd0};
        vecs[4]  = '{23'h03FF00, 0,       1'b1, 1'b0, 23'h03FF00, 24'h040000, 16'h0001, 8'd0};
        vecs[5]  = '{23'h000000, 1,       1'b1, 1'b0, 23'h000000, 24'hFC0100, 16'h0001, 8'd0};
        vecs[6]  = '{23'h040001, 0,       1'b0, 1'b1, 23'h000000, 24'hFC0100, 16'h0001, 8'd1};
        vecs[7]  = '{23'h000010, 0,       1'b1, 1'b0, 23'h000010, 24'h000010, 16'h0001, 8'd1};
        vecs[8]  = '{23'h300000, 0,       1'b0, 1'b1, 23'h000010, 24'h000010, 16'h0001, 8'd2};
        vecs[9]  = '{23'h300000, 5,       1'b0, 1'b1, 23'h000010, 24'h000010, 16'h0001, 8'd3};
        vecs[10] = '{23'h300000, 0,       1'b1, 1'b0, 23'h300000, 24'h000000, 16'h0001, 8'd3};
        vecs[11] = '{23'h300100, 2,       1'b1, 1'b0, 23'h300100, 24'h000100, 16'h0001, 8'd3};

        // Reset state.
        tick();
        tick();
        check("rst key_out", 32'(key_out), 32'd0);
        check("rst pos", 32'(pos_out), 32'd0);
        check("rst turn", 32'(turn_out), 32'd0);
        check("rst vel", 32'(vel_out), 32'd0);
        check("rst pulses", 32'({pos_valid, err_jump, err_tmo}), 32'd0);
        check("rst err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        tick();
        en = 1'b1;

        // Table: decode, wrap in both directions, DELTA_MAX boundary, rejection.
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("row%0d", i));
        end

        // en drop mid-WAIT: next cycle is IDLE, so a valid frame is ignored.
        wait_key(n);
        tick();
        tick();
        tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        angle_in    = to_gray(23'h055555);
        angle_valid = 1'b1;
        tick();
        angle_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen = seen | pos_valid | err_tmo | err_jump;
            tick();
        end
        check("endrop no_pulse", 32'(seen), 32'd0);
        check("endrop pos_held", 32'(pos_out), 32'h300100);
        check("endrop turn_held", 32'(turn_out), 32'd1);
        check("endrop err_held", 32'(err_cnt), 32'd3);
        wait_key(n);
        check("endrop req_delay", 32'(n + 5), 32'(T_REQ));
        // First frame after re-enable is accepted unchecked (would be a jump).
        v = '{23'h012345, 2, 1'b1, 1'b0, 23'h012345, 24'h000000, 16'h0001, 8'd3};
        run_vec(v, "reenable");

        // Reset pulse while in CALC: everything clears, no stale pos_valid.
        wait_key(n);
        tick();
        angle_in    = to_gray(23'h012350);
        angle_valid = 1'b1;
        tick();
        angle_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("calcrst pos", 32'(pos_out), 32'd0);
        check("calcrst turn", 32'(turn_out), 32'd0);
        check("calcrst err_cnt", 32'(err_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            seen = seen | pos_valid;
            tick();
        end
        check("calcrst no_pv", 32'(seen), 32'd0);
        check("calcrst vel", 32'(vel_out), 32'd0);

        // No frames: request period, timeout latency, error-count saturation.
        wait_key(n);
        for (int i = 0; i < 260; i++) begin
            n = 0;
            while ((err_tmo !== 1'b1) && (n < T_REQ + 5)) begin
                tick();
                n++;
            end
            if (i < 3) check($sformatf("tmo_lat%0d", i), 32'(n), 32'(T_TMO));
            if (i == 0) check("err_cnt_first", 32'(err_cnt), 32'd1);
            if (i == 1) check("err_cnt_second", 32'(err_cnt), 32'd2);
            while ((key_out !== 1'b1) && (n < 2 * T_REQ)) begin
                tick();
                n++;
            end
            if (i < 3) check($sformatf("req_period%0d", i), 32'(n), 32'(T_REQ));
        end
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
        check("tmo pos_held", 32'(pos_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ssi_angle_track.md
SSI_ANGLE_TRACK -- requirements
Module: ssi_angle_track

Interface
REQ-001 SHALL have parameter CNT_REQ, default 20000, request period in clk cycles (100 us at 200 MHz).
REQ-002 SHALL have parameter CNT_TMO, default 16000, frame timeout in clk cycles (80 us).
REQ-003 SHALL have parameter GRAY_EN, default 1: 1 means angle_in is Gray code, 0 means it is binary.
REQ-004 SHALL have parameter DELTA_MAX, default 262144, maximum plausible per-frame change in LSB.
REQ-005 SHALL have port clk, input, 1, 200 MHz system clock.
REQ-006 SHALL have port rst, input, 1, reset; one clock, asynchronous, active-high.
REQ-007 SHALL have port en, input, 1, tracking enable.
REQ-008 SHALL have port angle_in, input, 23, single-turn angle frame from the SSI reader.
REQ-009 SHALL have port angle_valid, input, 1, one-cycle strobe that angle_in holds a new frame.
REQ-010 SHALL have port key_out, output, 1, one-cycle request pulse to the SSI reader key input.
REQ-011 SHALL have port pos_out, output, 23, binary single-turn position.
REQ-012 SHALL have port turn_out, output, 16, signed multi-turn count.
REQ-013 SHALL have port vel_out, output, 24, signed delta per accepted frame.
REQ-014 SHALL have port pos_valid, output, 1, one-cycle strobe on each output update.
REQ-015 SHALL have port err_jump, output, 1, one-cycle strobe when a frame is rejected.
REQ-016 SHALL have port err_tmo, output, 1, one-cycle strobe on timeout.
REQ-017 SHALL have port err_cnt, output, 8, saturating error count.

Function
REQ-018 SHALL implement an FSM with states IDLE, REQ, WAIT and CALC, one-hot encoded.
REQ-019 SHALL hold a free-running period counter while en=1 and cycle IDLE->REQ when it reaches CNT_REQ-1, then reload it to 0.
REQ-020 SHALL assert key_out for exactly one cycle in REQ, then enter WAIT and clear the timeout counter.
REQ-021 SHALL, in WAIT, on angle_valid=1, register angle_in (Gray-decoded when GRAY_EN=1: b[22]=g[22], b[i]=b[i+1]^g[i]) and enter CALC.
REQ-022 SHALL, in WAIT, on timeout counter = CNT_TMO-1 without angle_valid, pulse err_tmo, increment err_cnt and return to IDLE with outputs unchanged.
REQ-023 SHALL ignore angle_valid in any state other than WAIT.
REQ-024 SHALL give angle_valid priority over timeout when both occur in the same cycle.
REQ-025 SHALL, in CALC, compute d = (new - old) mod 2^23, interpreted as signed 23-bit and sign-extended to 24 bits.
REQ-026 SHALL, for the first frame after reset or en rising, accept without a check: pos_out=new, vel_out=0, turn_out unchanged, pos_valid pulsed.
REQ-027 SHALL reject a frame when |d| > DELTA_MAX: pulse err_jump, increment err_cnt, leave pos_out/turn_out/vel_out unchanged and keep pos_valid low.
REQ-028 SHALL, on the 3rd consecutive rejected frame, instead accept it as a first frame (REQ-026) and clear the reject counter.
REQ-029 SHALL, on an accepted frame, set pos_out=new and vel_out=d; turn_out+1 if new<old and d>0; turn_out-1 if new>old and d<0.
REQ-030 SHALL let turn_out wrap modulo 2^16.
REQ-031 SHALL let err_cnt saturate at 255.
REQ-032 SHALL update outputs and pulse pos_valid in the cycle after CALC, giving angle_valid-to-pos_valid latency = 2 clk.
REQ-033 SHALL, on en=0, go to IDLE next cycle from any state, clear the period counter, arm the first-frame flag, and hold pos_out, turn_out and err_cnt.

Reset
REQ-034 SHALL, on rst=1, asynchronously set state=IDLE and clear all counters and outputs (key_out, pos_out, turn_out, vel_out, pos_valid, err_jump, err_tmo, err_cnt) to 0.
REQ-035 SHALL arm the first-frame flag on reset.
REQ-036 SHALL abandon any frame in progress when reset asserts mid-WAIT or mid-CALC, with no stale pos_valid after release.

Structure
REQ-037 SHALL place in a shared package: FSM state encodings, ANGLE_W=23, TURN_W=16 and default CNT_REQ/CNT_TMO values.
REQ-038 SHALL implement Gray-to-binary conversion as sub-module ssi_gray2bin (combinational, width-parameterised).

Verification
REQ-039 SHALL verify request period: en=1, no frames -> key_out pulses every 20000 cycles, err_tmo pulses 16000 cycles after each key_out, err_cnt counts up and saturates at 255.
REQ-040 SHALL verify decode and latency: GRAY_EN=1, angle_in=Gray(0x12345) -> pos_out=0x12345 with pos_valid 2 clk after angle_valid.
REQ-041 SHALL verify forward wrap: frames 0x7FFF00 then 0x000100 -> vel_out=+512, turn_out=1; reverse sequence -> vel_out=-512, turn_out=0.
REQ-042 SHALL verify jump rejection: accepted 0x000000 then 0x300000 twice -> two err_jump pulses with pos_out held; a third 0x300000 -> accepted, vel_out=0.
REQ-043 SHALL verify boundary: angle_valid coincident with timeout-1 -> frame accepted, no err_tmo.
REQ-044 SHALL verify en drop mid-WAIT -> IDLE next cycle; after re-enable, first frame gives vel_out=0.
REQ-045 SHALL verify rst pulse mid-CALC -> all outputs 0 and no pos_valid.
